// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - instruction memory port and decode handoff bundle for fetch_ctrl
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_pc, inst_data,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_pc, inst_data,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - single-outstanding instruction fetch sequencer with redirect squash
module fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          jmp_i,
  input  logic [31:0]   target_branch_i,
  fetch_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic        buf_free;
  logic        req;
  logic [31:0] redirect_pc;

  // A new request is only legal when the buffer will have room for its response.
  assign buf_free    = !inst_valid_q || bus.inst_ready;
  assign req         = rst_ni && (state_q == FETCH) && buf_free && !jmp_i;
  assign redirect_pc = target_branch_i & 32'hFFFF_FFFC;

  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_data  = inst_data_q;

  // Next-state: redirect overrides everything; otherwise issue, collect or drop.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    inst_valid_d = inst_valid_q;
    inst_pc_d    = inst_pc_q;
    inst_data_d  = inst_data_q;

    if (inst_valid_q && bus.inst_ready) begin
      inst_valid_d = 1'b0;
    end

    if (jmp_i) begin
      pc_d         = redirect_pc;
      inst_valid_d = 1'b0;
      case (state_q)
        WAIT:    state_d = bus.imem_rvalid ? FETCH : DROP;
        DROP:    state_d = bus.imem_rvalid ? FETCH : DROP;
        default: state_d = FETCH;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (req && bus.imem_gnt) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
            state_d  = WAIT;
          end
        end
        WAIT: begin
          if (bus.imem_rvalid) begin
            inst_valid_d = 1'b1;
            inst_pc_d    = req_pc_q;
            inst_data_d  = bus.imem_rdata;
            state_d      = FETCH;
          end
        end
        DROP: begin
          if (bus.imem_rvalid) begin
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // State and output buffer registers; reset abandons any outstanding request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= FETCH;
      pc_q         <= RESET_VECTOR;
      req_pc_q     <= 32'h0;
      inst_valid_q <= 1'b0;
      inst_pc_q    <= 32'h0;
      inst_data_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      inst_valid_q <= inst_valid_d;
      inst_pc_q    <= inst_pc_d;
      inst_data_q  <= inst_data_d;
    end
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer sitting between the core's program counter and the instruction memory port. It owns the PC, issues one request at a time to a variable-latency instruction memory, and buffers the returned word in a one-entry output register handed to decode with a valid/ready handshake. It also applies branch/jump redirects from the control unit, squashing any in-flight or buffered fetch from the old path.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- jmp  in  1  redirect request from control unit
- target_branch  in  32  redirect target, bits [1:0] ignored (treated as 00)
- imem_req  out  1  memory request valid
- imem_addr  out  32  request address (word aligned)
- imem_gnt  in  1  memory accepts request this cycle (meaningful only with imem_req=1)
- imem_rvalid  in  1  read data returned this cycle
- imem_rdata  in  32  returned instruction word
- inst_valid  out  1  output buffer holds an instruction
- inst_pc  out  32  address of buffered instruction
- inst_data  out  32  buffered instruction word
- inst_ready  in  1  decode consumes buffer this cycle

## Operation
- Registers: pc, req_pc, state, output buffer (inst_valid, inst_pc, inst_data).
- buf_free = !inst_valid || inst_ready.
- States:
  - FETCH: imem_req = buf_free && !jmp; imem_addr = pc. On imem_req && imem_gnt: req_pc <= pc, pc <= pc + 4 (mod 2^32, wraps FFFF_FFFC -> 0000_0000), -> WAIT.
  - WAIT: one request outstanding, imem_req=0. On imem_rvalid (no jmp): buffer <= {1, req_pc, imem_rdata}, -> FETCH.
  - DROP: outstanding response belongs to squashed path. On imem_rvalid: discard, -> FETCH.
- imem_rvalid in FETCH is a protocol error; ignored.
- Redirect (jmp=1), highest priority, any state:
  - pc <= {target_branch[31:2], 2'b00}; inst_valid <= 0 (buffer squashed even if inst_ready=1).
  - FETCH -> FETCH (no request granted since imem_req gated by jmp).
  - WAIT without rvalid -> DROP; WAIT with rvalid same cycle -> response discarded, -> FETCH.
  - DROP without rvalid -> DROP (pc updated); with rvalid -> FETCH.
- Buffer: cleared on inst_ready && inst_valid unless refilled the same cycle; refill only from WAIT response. Invariant: at most one outstanding request and one buffered instruction; a response never finds the buffer full.
- Memory may see imem_addr change while imem_req=1 and imem_gnt=0 (after redirect); memory must sample address only on grant.

## Timing
- Reset (rst=0, async): state=FETCH, pc=RESET_VECTOR, req_pc=0, inst_valid=0, inst_pc=0, inst_data=0; imem_req forced 0 while rst=0; imem_addr=RESET_VECTOR.
- First cycle after release: imem_req=1, imem_addr=RESET_VECTOR.
- Reset mid-transaction: outstanding request abandoned; instruction memory shares rst and drops it.
- Latency: gnt in cycle t, rvalid earliest t+1, inst_valid=1 in t+2. Next request issued in t+2 if buf_free.
- Peak throughput with zero-wait memory and inst_ready=1: one instruction per 2 cycles.
- Redirect at cycle t in FETCH: imem_addr=target from t+1; inst_valid=0 from t+1.
- Stall: inst_ready=0 with buffer full holds imem_req=0; outputs stable until consumed.

## Test plan
- Reset/sequential: RESET_VECTOR=0x100, gnt=1 every cycle, rvalid 1 cycle after gnt, ready=1 -> inst_pc sequence 0x100, 0x104, 0x108, one valid every 2 cycles, data matches memory.
- Backpressure: hold inst_ready=0 for 5 cycles with buffer full -> imem_req=0 throughout, inst_pc/inst_data stable; release -> next request next cycle.
- Redirect while waiting: request 0x200 granted, jmp=1 target 0x400 before rvalid -> response for 0x200 discarded, next imem_addr=0x400, first inst_pc=0x400.
- Redirect coincident with rvalid and with full buffer: jmp target 0x803 -> buffered and returning words squashed, next request address 0x800.
- Wrap-around: RESET_VECTOR=0xFFFF_FFFC -> inst_pc 0xFFFF_FFFC then 0x0000_0000.
- Async reset asserted in WAIT with buffer valid -> inst_valid=0, imem_req=0 immediately; after release imem_addr=RESET_VECTOR, late rvalid ignored.
